// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : mux4_arb_pkg

// File: rtl/rr_pick4.sv
// Rotate-and-priority selector: finds the first asserted request starting at
// index ptr and wrapping modulo 4. Purely combinational.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Doubling the vector lets a plain part-select perform the rotation.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: NUM_REQ];

  // Lowest set bit of the rotated vector is the offset from ptr.
  always_comb begin
    w_off = 2'd0;
    if (w_rot[0]) begin
      w_off = 2'd0;
    end else if (w_rot[1]) begin
      w_off = 2'd1;
    end else if (w_rot[2]) begin
      w_off = 2'd2;
    end else if (w_rot[3]) begin
      w_off = 2'd3;
    end else begin
      w_off = 2'd0;
    end
  end

  assign any = |req;
  // Two-bit addition wraps 3 -> 0 naturally.
  assign idx = ptr + w_off;

endmodule : rr_pick4

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 4-to-1 data mux.
// Optional hold-limit (timeout) feature: define MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_busy;
  logic               r_timeout;
  logic [SEL_W-1:0]   r_ptr;

  logic               w_any;
  logic [SEL_W-1:0]   w_idx;
  logic               w_rel_normal;
  logic               w_hold_expire;

  rr_pick4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Consumer completion or requester withdrawal ends the grant.
  assign w_rel_normal = done | ~req[r_sel];

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Hold counter: counts GRANT cycles, zero whenever the grant is not continuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == GRANT) && !w_rel_normal && !w_hold_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // The grant has used its last allowed cycle.
  assign w_hold_expire = (r_state == GRANT) && (r_cnt == CNT_W'(MAX_HOLD - 1));
`else
  // Without the hold limit the grant never expires; the sizing parameters
  // only fold into a constant zero here.
  assign w_hold_expire = (MAX_HOLD < 0) && (CNT_W < 0);
`endif

  // Arbitration FSM; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_any) begin
            r_state <= GRANT;
            r_gnt   <= NUM_REQ'(1) << w_idx;
            r_sel   <= w_idx;
            r_busy  <= 1'b1;
          end else begin
            // sel keeps the last index so the mux output does not glitch.
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (w_rel_normal) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= r_sel + 2'd1;
          end else if (w_hold_expire) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_ptr     <= r_sel + 2'd1;
          end else begin
            r_state   <= GRANT;
            r_timeout <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= '0;
          r_busy    <= 1'b0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a driver applies directed and random
// stimulus, steps a behavioural model and queues the expected outputs; a
// monitor compares them against the DUT one cycle later.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;
`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model: who holds the channel, priority pointer, cycles held.
  bit m_busy = 1'b0;
  bit m_to   = 1'b0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_held = 0;

  // Grant-order log for the fairness phase, gathered from DUT outputs only.
  bit   log_en = 1'b0;
  int   grant_log[$];
  logic prev_busy = 1'b0;

  task automatic release_grant(input bit by_timeout);
    m_busy = 1'b0;
    m_ptr  = (m_sel + 1) % 4;
    m_to   = by_timeout;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d, input logic rs);
    exp_t e;
    bit   found;
    if (rs) begin
      m_busy = 1'b0; m_to = 1'b0; m_sel = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int off = 0; off < 4; off++) begin
        if (!found && r[(m_ptr + off) % 4]) begin
          found = 1'b1;
          m_sel = (m_ptr + off) % 4;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_held = 1;
      end
    end else begin
      if (d || !r[m_sel]) begin
        release_grant(1'b0);
      end else if (TO_EN && (m_held >= MAX_HOLD)) begin
        release_grant(1'b1);
      end else begin
        m_held = m_held + 1;
        m_to   = 1'b0;
      end
    end
    e.gnt     = m_busy ? 4'(1 << m_sel) : 4'b0000;
    e.sel     = 2'(m_sel);
    e.busy    = m_busy;
    e.timeout = m_to;
    sb_q.push_back(e);
  endtask

  // One cycle of stimulus, applied on the falling edge.
  task automatic cyc(input logic [3:0] r, input logic d, input logic rs);
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    model_step(r, d, rs);
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pop and compare one expectation per cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (log_en && (busy === 1'b1) && (prev_busy !== 1'b1)) begin
        grant_log.push_back(int'(sel));
      end
      prev_busy = busy;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("gnt",     gnt,               e.gnt);
        chk("sel",     {2'b00, sel},      {2'b00, e.sel});
        chk("busy",    {3'b000, busy},    {3'b000, e.busy});
        chk("timeout", {3'b000, timeout}, {3'b000, e.timeout});
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    int         exp_order[5];
    logic [3:0] r;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset, single request, release leaves ptr at 3 (seen via req=1111).
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);

    // Fairness: all request, done on every grant cycle.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    log_en = 1'b1;
    repeat (10) cyc(4'b1111, m_busy, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    log_en = 1'b0;
    chk("fair_len", 4'(grant_log.size()), 4'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) begin
        chk("fair_order", 4'(grant_log[i]), 4'(exp_order[i]));
      end
    end

    // Wrap-around 3 -> 0, then 3 again.
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1001, 1'b1, 1'b0);
    cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);

    // Stability under competing requests, then withdrawal.
    cyc(4'b0010, 1'b0, 1'b0);
    repeat (3) cyc(4'b1110, 1'b0, 1'b0);
    cyc(4'b1100, 1'b0, 1'b0);
    cyc(4'b1100, 1'b0, 1'b0);
    cyc(4'b1100, 1'b1, 1'b0);

    // Hold limit (or indefinite hold when the feature is compiled out).
    cyc(4'b0000, 1'b0, 1'b0);
    repeat (20) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Reset in the middle of a grant to index 3.
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1);
    repeat (4) cyc(4'b1111, m_busy, 1'b0);

    // Randomized traffic with sticky requests and occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mux4_rr_arbiter
